// File: rtl/arb_pkg.sv
// Shared constants, state type and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [ID_W-1:0] RESET_PTR = 3'd7;

  // Binary index of the single set bit; 0 for an all-zero vector.
  function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (oh[i]) id = id | ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request scanning upward from last+1.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] pick_onehot,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_any
);

  logic [ID_W-1:0]    start;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   iso;
  logic [2*N_REQ-1:0] back_dbl;

  // Rotate so last+1 sits at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    start       = last + 3'd1;
    rot_dbl     = {req, req} >> start;
    rot         = rot_dbl[N_REQ-1:0];
    iso         = rot & (~rot + 8'd1);
    back_dbl    = {iso, iso} << start;
    pick_onehot = back_dbl[2*N_REQ-1:N_REQ];
    pick_id     = onehot_to_id(pick_onehot);
    pick_any    = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with held grants, release on done,
// request drop, disable, or hold timeout.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last, last_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic [ID_W-1:0]   grant_id_nxt;
  logic              grant_valid_nxt;
  logic              timeout_nxt;

  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              rel_other;
  logic              rel_expire;

  rr_pick8 u_pick (
    .req         (req),
    .last        (last),
    .pick_onehot (pick_onehot),
    .pick_id     (pick_id),
    .pick_any    (pick_any)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    last_nxt        = last;
    hold_nxt        = hold;
    grant_nxt       = grant;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    timeout_nxt     = 1'b0;
    rel_other       = done | ~req[grant_id] | ~enable;
    rel_expire      = HOLD_EN && (hold == HOLD_LAST);

    case (state)
      IDLE: begin
        if (enable && pick_any) begin
          state_nxt       = BUSY;
          last_nxt        = pick_id;
          hold_nxt        = '0;
          grant_nxt       = pick_onehot;
          grant_id_nxt    = pick_id;
          grant_valid_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (rel_other || rel_expire) begin
          state_nxt       = IDLE;
          hold_nxt        = '0;
          grant_nxt       = '0;
          grant_id_nxt    = '0;
          grant_valid_nxt = 1'b0;
          // Timeout only flags a revocation the owner did not cause itself.
          timeout_nxt     = rel_expire & ~rel_other;
        end else if (hold != HOLD_SAT) begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt       = IDLE;
        grant_nxt       = '0;
        grant_id_nxt    = '0;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= RESET_PTR;
      hold        <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      hold        <= hold_nxt;
      grant       <= grant_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule
